// File: rtl/hex_scan_pkg.sv
// Shared types, constants and the hex glyph table for the multiplexed
// 7-segment scan driver.
package hex_scan_pkg;

   typedef logic [7:0] seg7_t;

   localparam seg7_t SEG_BLANK = 8'hFF;

   typedef enum logic {
      GAP = 1'b0,
      ON  = 1'b1
   } scan_state_t;

   // Bits needed to count 0..max_count-1, never less than one bit.
   function automatic int width_of(input int max_count);
      return (max_count <= 2) ? 1 : $clog2(max_count);
   endfunction

   // Active-high glyphs {dp,g,f,e,d,c,b,a}; dp is always returned as 0.
   function automatic seg7_t nibble_to_seg7(input logic [3:0] nib);
      seg7_t glyph;
      case (nib)
         4'h0: glyph = 8'h3F;
         4'h1: glyph = 8'h06;
         4'h2: glyph = 8'h5B;
         4'h3: glyph = 8'h4F;
         4'h4: glyph = 8'h66;
         4'h5: glyph = 8'h6D;
         4'h6: glyph = 8'h7D;
         4'h7: glyph = 8'h07;
         4'h8: glyph = 8'h7F;
         4'h9: glyph = 8'h6F;
         4'hA: glyph = 8'h77;
         4'hB: glyph = 8'h7C;
         4'hC: glyph = 8'h39;
         4'hD: glyph = 8'h5E;
         4'hE: glyph = 8'h79;
         default: glyph = 8'h71;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// Bundle of the display data inputs and the board-facing pin outputs.
// The master side supplies digits/dp/blank/brightness, the slave side
// (the scan driver) produces the segment, grid and frame pulse outputs.
interface hex_scan_driver_if
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 4
);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [BRIGHT_W-1:0]     brightness;
   seg7_t                   hex_seg;
   logic [NUM_DIGITS-1:0]   hex_grid;
   logic                    frame_start;

   modport master (
      output digits_in, dp_in, blank_in, brightness,
      input  hex_seg, hex_grid, frame_start
   );

   modport slave (
      input  digits_in, dp_in, blank_in, brightness,
      output hex_seg, hex_grid, frame_start
   );

endinterface

// File: rtl/hex_scan_pwm.sv
// Brightness PWM for one digit window. The counter restarts at every entry
// into ON, free-runs while ON and holds during GAP. drive_en is the enable
// for the cycle that follows the current clock edge, so it lines up with
// the registered pin outputs of the scan driver.
module hex_scan_pwm #(
   parameter int BRIGHT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                run,
   input  logic [BRIGHT_W-1:0] level,
   output logic                drive_en
);

   localparam logic [BRIGHT_W-1:0] ONE = BRIGHT_W'(1);

   logic [BRIGHT_W-1:0] pwm_cnt;
   logic [BRIGHT_W-1:0] pwm_nxt;

   // Next counter value: zero on ON entry, increment while ON, else hold.
   always_comb begin
      pwm_nxt = pwm_cnt;
      if (start) begin
         pwm_nxt = '0;
      end else if (run) begin
         pwm_nxt = pwm_cnt + ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_nxt;
      end
   end

   // Full-scale level means always on, otherwise compare against the count.
   assign drive_en = (&level) | (pwm_nxt < level);

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit gets a GAP (all grids off) followed by an ON window. Inputs are
// snapshotted once per frame on entry into digit 0, so a frame is always
// coherent. All pins are registered from the next-state decisions, so
// grid, seg and frame_start line up with the FSM state and never skew.
// Optional feature macro: HEX_SCAN_LZB_EN enables leading-zero blanking.
module hex_scan_driver
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int TICKS_PER_DIGIT = 32768,
   parameter int GAP_TICKS       = 256,
   parameter int BRIGHT_W        = 4
) (
   input logic               clk,
   input logic               reset,
   hex_scan_driver_if.slave  bus
);

   localparam int IDX_W  = width_of(NUM_DIGITS);
   localparam int TICK_W = width_of(TICKS_PER_DIGIT);
   localparam int GAP_W  = width_of(GAP_TICKS);
   localparam int CNT_W  = (TICK_W > GAP_W) ? TICK_W : GAP_W;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 1) ? GAP_TICKS - 1 : 0);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] ONE_I    = IDX_W'(1);

   scan_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             snap;

   logic [4*NUM_DIGITS-1:0] sh_digits, sh_digits_nxt;
   logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nxt;
   logic [NUM_DIGITS-1:0]   sh_blank, sh_blank_nxt;
   logic [BRIGHT_W-1:0]     sh_bright, sh_bright_nxt;

   logic                  pwm_drive;
   logic                  lz_hit;
   logic [3:0]            nib;
   seg7_t                 glyph;
   seg7_t                 lit;
   logic                  show;
   logic [NUM_DIGITS-1:0] onehot;
   seg7_t                 seg_nxt;
   logic [NUM_DIGITS-1:0] grid_nxt;

   // Scan sequencing: GAP counts its dead time, ON counts the digit window,
   // the digit index advances when an ON window ends.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      snap      = 1'b0;
      case (state)
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = ON;
               cnt_nxt   = '0;
               snap      = (idx == '0);
            end else begin
               cnt_nxt = cnt + ONE_C;
            end
         end
         ON: begin
            if (cnt == ON_LAST) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
               idx_nxt   = (idx == IDX_LAST) ? '0 : idx + ONE_I;
            end else begin
               cnt_nxt = cnt + ONE_C;
            end
         end
         default: begin
            state_nxt = GAP;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and index registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= GAP;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Shadow values seen by the next cycle: fresh inputs on a frame snapshot.
   always_comb begin
      sh_digits_nxt = snap ? bus.digits_in  : sh_digits;
      sh_dp_nxt     = snap ? bus.dp_in      : sh_dp;
      sh_blank_nxt  = snap ? bus.blank_in   : sh_blank;
      sh_bright_nxt = snap ? bus.brightness : sh_bright;
   end

   // Shadow registers holding the frame-coherent copy of the inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_digits <= '0;
         sh_dp     <= '0;
         sh_blank  <= '0;
         sh_bright <= '0;
      end else begin
         sh_digits <= sh_digits_nxt;
         sh_dp     <= sh_dp_nxt;
         sh_blank  <= sh_blank_nxt;
         sh_bright <= sh_bright_nxt;
      end
   end

   hex_scan_pwm #(
      .BRIGHT_W (BRIGHT_W)
   ) u_pwm (
      .clk      (clk),
      .reset    (reset),
      .start    ((state == GAP) && (state_nxt == ON)),
      .run      (state_nxt == ON),
      .level    (sh_bright_nxt),
      .drive_en (pwm_drive)
   );

`ifdef HEX_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lz_mask;

   // A digit is a leading zero if it and every higher nibble are zero;
   // digit 0 always shows so a zero value still reads as "0".
   always_comb begin
      logic zero_run;
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run   = zero_run & (sh_digits_nxt[4*i +: 4] == 4'h0);
         lz_mask[i] = zero_run & (i != 0);
      end
   end

   assign lz_hit = lz_mask[idx_nxt];
`else
   assign lz_hit = 1'b0;
`endif

   // Pin values for the coming cycle: glyph plus dp for the active digit,
   // dark whenever in GAP, blanked, PWM-off, or a leading zero without dp.
   always_comb begin
      nib    = sh_digits_nxt[4*int'(idx_nxt) +: 4];
      glyph  = nibble_to_seg7(nib);
      lit    = lz_hit ? {sh_dp_nxt[idx_nxt], 7'b0}
                      : (glyph | {sh_dp_nxt[idx_nxt], 7'b0});
      show   = (state_nxt == ON) && !sh_blank_nxt[idx_nxt] && pwm_drive &&
               (lit != 8'h00);
      onehot = '0;
      onehot[idx_nxt] = 1'b1;
      seg_nxt  = show ? ~lit : SEG_BLANK;
      grid_nxt = show ? ~onehot : '1;
   end

   // Registered pins, updated together so grid and seg never skew.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.hex_seg     <= SEG_BLANK;
         bus.hex_grid    <= '1;
         bus.frame_start <= 1'b0;
      end else begin
         bus.hex_seg     <= seg_nxt;
         bus.hex_grid    <= grid_nxt;
         bus.frame_start <= snap;
      end
   end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with 4 digits, 8-cycle ON windows and
// 2-cycle gaps. Whole frames are captured starting at a frame_start pulse
// and compared against hand-computed glyphs and lit-cycle counts.
module tb_hex_scan_driver;

   localparam int ND    = 4;
   localparam int TPD   = 8;
   localparam int GT    = 2;
   localparam int BW    = 2;
   localparam int SLOT  = TPD + GT;
   localparam int FRAME = ND * SLOT;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int check_count = 0;
   int pass_count  = 0;

   logic [3:0] cap_grid [FRAME];
   logic [7:0] cap_seg  [FRAME];

   hex_scan_driver_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus_if ();

   hex_scan_driver #(
      .NUM_DIGITS      (ND),
      .TICKS_PER_DIGIT (TPD),
      .GAP_TICKS       (GT),
      .BRIGHT_W        (BW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point for every check in the bench.
   task automatic check_output(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
      check_count++;
      if (got === exp) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance n clock cycles and settle just after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the display data inputs.
   task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dp,
                                 input logic [3:0] bl, input logic [1:0] br);
      bus_if.digits_in  = d;
      bus_if.dp_in      = dp;
      bus_if.blank_in   = bl;
      bus_if.brightness = br;
   endtask

   // Skip the current cycle, wait for the next frame_start and record one
   // full frame; the bench ends up on the following frame_start sample.
   task automatic capture_frame(input string tag);
      int waited = 0;
      int extra  = 0;
      step(1);
      while (bus_if.frame_start !== 1'b1 && waited < 100) begin
         step(1);
         waited++;
      end
      check_output($sformatf("%s frame_start seen", tag),
                   32'(bus_if.frame_start), 32'd1);
      for (int t = 0; t < FRAME; t++) begin
         cap_grid[t] = bus_if.hex_grid;
         cap_seg[t]  = bus_if.hex_seg;
         if (t > 0 && bus_if.frame_start === 1'b1) extra++;
         step(1);
      end
      check_output($sformatf("%s extra frame_start", tag), 32'(extra), 32'd0);
      check_output($sformatf("%s frame period", tag),
                   32'(bus_if.frame_start), 32'd1);
   endtask

   // Per digit: count lit cycles and the glyph shown; flag any stray grid
   // pattern, gap activity or non-blank seg while grids are off.
   task automatic analyze(input string tag, input logic [31:0] exp_segs,
                          input logic [15:0] exp_lits);
      int bad = 0;
      for (int d = 0; d < ND; d++) begin
         logic [3:0] on_pat;
         logic [7:0] segv;
         int lit = 0;
         on_pat = ~(4'b0001 << d);
         segv   = 8'hFF;
         for (int p = 0; p < SLOT; p++) begin
            int t = d * SLOT + p;
            if (p < TPD && cap_grid[t] == on_pat) begin
               if (lit == 0) segv = cap_seg[t];
               else if (cap_seg[t] != segv) bad++;
               lit++;
            end else if (cap_grid[t] != 4'hF) begin
               bad++;
            end
            if (cap_grid[t] == 4'hF && cap_seg[t] != 8'hFF) bad++;
         end
         check_output($sformatf("%s digit%0d lit cycles", tag, d),
                      32'(lit), 32'(exp_lits[4*d +: 4]));
         if (exp_lits[4*d +: 4] != 4'd0) begin
            check_output($sformatf("%s digit%0d seg", tag, d),
                         32'(segv), 32'(exp_segs[8*d +: 8]));
         end
      end
      check_output($sformatf("%s stray activity", tag), 32'(bad), 32'd0);
   endtask

   // Count cycles from reset release to the first frame_start.
   task automatic release_and_check(input string tag);
      int n = 0;
      @(negedge clk);
      reset = 1'b0;
      while (bus_if.frame_start !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output($sformatf("%s cycles to frame_start", tag), 32'(n), 32'd2);
      check_output($sformatf("%s first grid", tag), 32'(bus_if.hex_grid), 32'hE);
      check_output($sformatf("%s first seg", tag), 32'(bus_if.hex_seg), 32'h99);
   endtask

   // Directed test sequence.
   initial begin
      apply_stimulus(16'h1234, 4'b0000, 4'b0000, 2'd3);
      reset = 1'b1;
      step(3);
      check_output("reset seg", 32'(bus_if.hex_seg), 32'hFF);
      check_output("reset grid", 32'(bus_if.hex_grid), 32'hF);
      check_output("reset frame_start", 32'(bus_if.frame_start), 32'd0);
      release_and_check("startup");

      capture_frame("base");
      analyze("base", 32'hF9A4B099, 16'h8888);

      step(20);
      check_output("mid digit2 grid", 32'(bus_if.hex_grid), 32'hB);
      check_output("mid digit2 seg", 32'(bus_if.hex_seg), 32'hA4);
      apply_stimulus(16'hABCD, 4'b0000, 4'b0000, 2'd3);
      step(10);
      check_output("mid digit3 grid", 32'(bus_if.hex_grid), 32'h7);
      check_output("mid digit3 seg held", 32'(bus_if.hex_seg), 32'hF9);
      capture_frame("abcd");
      analyze("abcd", 32'h8883C6A1, 16'h8888);

      apply_stimulus(16'hABCD, 4'b0000, 4'b0000, 2'd1);
      capture_frame("bright1");
      analyze("bright1", 32'h8883C6A1, 16'h2222);
      check_output("bright1 t0 grid", 32'(cap_grid[0]), 32'hE);
      check_output("bright1 t1 grid", 32'(cap_grid[1]), 32'hF);
      check_output("bright1 t4 grid", 32'(cap_grid[4]), 32'hE);
      check_output("bright1 t5 grid", 32'(cap_grid[5]), 32'hF);

      apply_stimulus(16'hABCD, 4'b0000, 4'b0000, 2'd0);
      capture_frame("bright0");
      analyze("bright0", 32'hFFFFFFFF, 16'h0000);

      apply_stimulus(16'h1234, 4'b0010, 4'b0100, 2'd3);
      capture_frame("blankdp");
      analyze("blankdp", 32'hF9FF3099, 16'h8088);

      apply_stimulus(16'h1234, 4'b0000, 4'b0000, 2'd3);
      capture_frame("prereset");
      analyze("prereset", 32'hF9A4B099, 16'h8888);
      step(22);
      check_output("pre-reset digit2 grid", 32'(bus_if.hex_grid), 32'hB);
      #2;
      reset = 1'b1;
      #1;
      check_output("async reset seg", 32'(bus_if.hex_seg), 32'hFF);
      check_output("async reset grid", 32'(bus_if.hex_grid), 32'hF);
      check_output("async reset frame_start", 32'(bus_if.frame_start), 32'd0);
      step(2);
      release_and_check("restart");

      apply_stimulus(16'h0005, 4'b0000, 4'b0000, 2'd3);
      capture_frame("lz0005");
`ifdef HEX_SCAN_LZB_EN
      analyze("lz0005", 32'hFFFFFF92, 16'h0008);
`else
      analyze("lz0005", 32'hC0C0C092, 16'h8888);
`endif

      apply_stimulus(16'h0000, 4'b0100, 4'b0000, 2'd3);
      capture_frame("lz0000");
`ifdef HEX_SCAN_LZB_EN
      analyze("lz0000", 32'hFF7FFFC0, 16'h0808);
`else
      analyze("lz0000", 32'hC040C0C0, 16'h8888);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
